// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - constants, state type and z0 lookup for the SIMON32/64 key-schedule controller
package simon_pkg;

    localparam int          SIMON_ROUNDS = 32;
    localparam logic [15:0] SIMON_C      = 16'hFFFC;

    // Written with sequence bit 0 as the leftmost (most significant) literal digit
    localparam logic [61:0] SIMON_Z0 =
        62'b11111010001001010110000111001101111101000100101011000011100110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_WAIT,
        ST_RESP
    } state_t;

    function automatic logic z0_bit(input logic [5:0] idx);
        return SIMON_Z0[6'd61 - idx];
    endfunction

endpackage

// File: rtl/simon_key_expand.sv
// rtl/simon_key_expand.sv - 4-word key window; advancing shifts out k[r] and appends k[r+4]
module simon_key_expand
    import simon_pkg::*;
#(
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          advance,
    input  logic [63:0]   key,
    input  logic [RW-1:0] round,
    output logic [15:0]   round_key
);

    logic [15:0] w [4];
    logic [15:0] tmp;
    logic [15:0] next_word;

    always_comb begin
        tmp       = {w[3][2:0], w[3][15:3]} ^ w[1];
        next_word = w[0] ^ tmp ^ {tmp[0], tmp[15:1]} ^ SIMON_C
                    ^ {15'd0, z0_bit(6'(round))};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                w[i] <= '0;
            end
        end else if (load) begin
            w[0] <= key[15:0];
            w[1] <= key[31:16];
            w[2] <= key[47:32];
            w[3] <= key[63:48];
        end else if (advance) begin
            w[0] <= w[1];
            w[1] <= w[2];
            w[2] <= w[3];
            w[3] <= next_word;
        end
    end

    assign round_key = w[0];

endmodule

// File: rtl/simon_key_sched_ctrl.sv
// rtl/simon_key_sched_ctrl.sv - request FSM, watchdog and arbiter for SIMON32/64 (SIMON_TWO_REQ_EN adds req1)
module simon_key_sched_ctrl
    import simon_pkg::*;
#(
    parameter int ROUNDS       = SIMON_ROUNDS,
    parameter int DONE_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [63:0] req0_key,
    input  logic [31:0] req0_plain,
`ifdef SIMON_TWO_REQ_EN
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [63:0] req1_key,
    input  logic [31:0] req1_plain,
`endif
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_cipher,
    output logic        resp_id,
    output logic        resp_err,
    output logic        core_start,
    output logic [31:0] core_plain,
    output logic [15:0] core_round_key,
    input  logic [31:0] core_cipher,
    input  logic        core_done
);

    localparam int RW = $clog2(ROUNDS);
    localparam int WW = $clog2(DONE_TIMEOUT + 1);

    state_t        state, state_nx;
    logic [RW-1:0] round;
    logic [WW-1:0] wd;
    logic          done_seen;
    logic          last_round;
    logic          timeout;
    logic          grant;
    logic          accept;
    logic [63:0]   sel_key;
    logic [31:0]   sel_plain;
    logic [15:0]   rk;

    assign last_round = (round == RW'(ROUNDS - 1));
    assign timeout    = (wd >= WW'(DONE_TIMEOUT - 1));

`ifdef SIMON_TWO_REQ_EN
    logic last_served;

    // With nobody asking, offer the slot to whoever was not served last
    always_comb begin
        grant = ~last_served;
        if (req0_valid && req1_valid) grant = ~last_served;
        else if (req1_valid)          grant = 1'b1;
        else if (req0_valid)          grant = 1'b0;
    end

    assign req0_ready = (state == ST_IDLE) && !reset && !grant;
    assign req1_ready = (state == ST_IDLE) && !reset &&  grant;
    assign accept     = grant ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
    assign sel_key    = grant ? req1_key   : req0_key;
    assign sel_plain  = grant ? req1_plain : req0_plain;

    always_ff @(posedge clk) begin
        if (reset)       last_served <= 1'b1;
        else if (accept) last_served <= grant;
    end
`else
    assign grant      = 1'b0;
    assign req0_ready = (state == ST_IDLE) && !reset;
    assign accept     = req0_valid && req0_ready;
    assign sel_key    = req0_key;
    assign sel_plain  = req0_plain;
`endif

    simon_key_expand #(.RW(RW)) u_key_expand (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .advance   (state == ST_RUN),
        .key       (sel_key),
        .round     (round),
        .round_key (rk)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept) state_nx = ST_RUN;
            ST_RUN:  if (last_round) state_nx = (done_seen || core_done) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (core_done || timeout) state_nx = ST_RESP;
            ST_RESP: if (resp_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // wd equals the number of cycles elapsed since the core_start cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            round       <= '0;
            wd          <= '0;
            done_seen   <= 1'b0;
            core_plain  <= '0;
            resp_cipher <= '0;
            resp_err    <= 1'b0;
            resp_id     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        core_plain <= sel_plain;
                        resp_id    <= grant;
                        round      <= '0;
                        wd         <= '0;
                        done_seen  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    round <= round + RW'(1);
                    wd    <= wd + WW'(1);
                    if (core_done && !done_seen) begin
                        done_seen   <= 1'b1;
                        resp_cipher <= core_cipher;
                        resp_err    <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    wd <= wd + WW'(1);
                    if (core_done) begin
                        resp_cipher <= core_cipher;
                        resp_err    <= 1'b0;
                    end else if (timeout) begin
                        resp_cipher <= '0;
                        resp_err    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_valid     = (state == ST_RESP);
    assign core_start     = (state == ST_RUN) && (round == '0);
    assign core_round_key = (state == ST_RUN) ? rk : '0;

endmodule

// File: tb/tb_simon_key_sched_ctrl.sv
// tb/tb_simon_key_sched_ctrl.sv - vector-table and randomized bench for simon_key_sched_ctrl (SIMON_TWO_REQ_EN optional)
module tb_simon_key_sched_ctrl;

    localparam int ROUNDS       = 32;
    localparam int DONE_TIMEOUT = 64;
    localparam int NVEC         = 8;

    typedef struct {
        logic [63:0] key;
        logic [31:0] plain;
        int          hold;
        int          delay;
        logic [31:0] exp_cipher;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready;
    logic [63:0] req0_key;
    logic [31:0] req0_plain;
`ifdef SIMON_TWO_REQ_EN
    logic        req1_valid, req1_ready;
    logic [63:0] req1_key;
    logic [31:0] req1_plain;
`endif
    logic        resp_valid, resp_ready, resp_id, resp_err;
    logic [31:0] resp_cipher;
    logic        core_start;
    logic [31:0] core_plain;
    logic [15:0] core_round_key;
    logic [31:0] core_cipher = 32'd0;
    logic        core_done   = 1'b0;

    int    n_vec = 0;
    int    n_bad = 0;
    int    core_delay = 0;
    string z0_str = "11111010001001010110000111001101111101000100101011000011100110";
    vec_t  vecs [NVEC];

    always #5 clk = ~clk;

    simon_key_sched_ctrl #(.ROUNDS(ROUNDS), .DONE_TIMEOUT(DONE_TIMEOUT)) dut (
        .clk            (clk),
        .reset          (reset),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_key       (req0_key),
        .req0_plain     (req0_plain),
`ifdef SIMON_TWO_REQ_EN
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_key       (req1_key),
        .req1_plain     (req1_plain),
`endif
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_cipher    (resp_cipher),
        .resp_id        (resp_id),
        .resp_err       (resp_err),
        .core_start     (core_start),
        .core_plain     (core_plain),
        .core_round_key (core_round_key),
        .core_cipher    (core_cipher),
        .core_done      (core_done)
    );

    function automatic logic [15:0] rol16(input logic [15:0] v, input int s);
        return (v << s) | (v >> (16 - s));
    endfunction

    function automatic logic [15:0] ror16(input logic [15:0] v, input int s);
        return (v >> s) | (v << (16 - s));
    endfunction

    function automatic logic [15:0] simon_f(input logic [15:0] x);
        return (rol16(x, 1) & rol16(x, 8)) ^ rol16(x, 2);
    endfunction

    function automatic logic [15:0] ref_round_key(input logic [63:0] key, input int idx);
        logic [15:0] k [ROUNDS];
        logic [15:0] t;
        for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
        for (int i = 4; i < ROUNDS; i++) begin
            t    = ror16(k[i-1], 3) ^ k[i-3];
            k[i] = ~k[i-4] ^ t ^ ror16(t, 1) ^ 16'h0003
                   ^ ((z0_str[i-4] == "1") ? 16'h0001 : 16'h0000);
        end
        return k[idx];
    endfunction

    function automatic logic [31:0] ref_encrypt(input logic [63:0] key, input logic [31:0] plain);
        logic [15:0] x, y, t;
        x = plain[31:16];
        y = plain[15:0];
        for (int i = 0; i < ROUNDS; i++) begin
            t = x;
            x = y ^ simon_f(x) ^ ref_round_key(key, i);
            y = t;
        end
        return {x, y};
    endfunction

    // Encrypt core stand-in: one round per cycle on the issued keys, done core_delay cycles after the last
    logic [15:0] cm_x, cm_y;
    int          cm_n, cm_wait;
    logic        cm_active = 1'b0;

    always @(negedge clk) begin
        core_done <= 1'b0;
        if (reset) begin
            cm_active <= 1'b0;
        end else if (core_start) begin
            cm_x      <= core_plain[15:0] ^ simon_f(core_plain[31:16]) ^ core_round_key;
            cm_y      <= core_plain[31:16];
            cm_n      <= 1;
            cm_wait   <= 0;
            cm_active <= 1'b1;
        end else if (cm_active && cm_n < ROUNDS) begin
            cm_x <= cm_y ^ simon_f(cm_x) ^ core_round_key;
            cm_y <= cm_x;
            cm_n <= cm_n + 1;
        end else if (cm_active) begin
            if (cm_wait == core_delay) begin
                core_done   <= 1'b1;
                core_cipher <= {cm_x, cm_y};
                cm_active   <= 1'b0;
            end
            cm_wait <= cm_wait + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_block(input vec_t v);
        int n;
        core_delay = v.delay;
        req0_key   = v.key;
        req0_plain = v.plain;
        req0_valid = 1'b1;
        resp_ready = 1'b0;
        n = 0;
        while (!req0_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("req0_ready_idle", 64'(req0_ready), 64'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        check("core_start", 64'(core_start), 64'd1);
        check("core_plain", 64'(core_plain), 64'(v.plain));
        for (int r = 0; r < ROUNDS; r++) begin
            if (r > 0) @(negedge clk);
            check($sformatf("round_key_%0d", r), 64'(core_round_key), 64'(ref_round_key(v.key, r)));
            if (r == 1) check("core_start_pulse", 64'(core_start), 64'd0);
        end
        n = ROUNDS - 1;
        while (!resp_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("resp_latency", 64'(n), 64'((v.delay < 0) ? DONE_TIMEOUT : ROUNDS + 1 + v.delay));
        check("resp_cipher", 64'(resp_cipher), 64'(v.exp_cipher));
        check("resp_err", 64'(resp_err), 64'(v.exp_err));
        check("resp_id", 64'(resp_id), 64'd0);
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(resp_valid), 64'd1);
            check("hold_cipher", 64'(resp_cipher), 64'(v.exp_cipher));
            check("hold_req_ready", 64'(req0_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("resp_retired", 64'(resp_valid), 64'd0);
    endtask

    initial begin
        vec_t v;
        int   n, starts, first, second, extra;

        reset      = 1'b1;
        req0_valid = 1'b0;
        req0_key   = '0;
        req0_plain = '0;
        resp_ready = 1'b0;
`ifdef SIMON_TWO_REQ_EN
        req1_valid = 1'b0;
        req1_key   = '0;
        req1_plain = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_core_start", 64'(core_start), 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        check("rst_resp_id", 64'(resp_id), 64'd0);
        check("rst_resp_cipher", 64'(resp_cipher), 64'd0);
        check("rst_core_plain", 64'(core_plain), 64'd0);
        check("rst_round_key", 64'(core_round_key), 64'd0);
        check("rst_req0_ready", 64'(req0_ready), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_req0_ready", 64'(req0_ready), 64'd1);

        vecs[0] = '{64'h1918_1110_0908_0100, 32'h6565_6877, 0, 0, 32'hC69B_E9BB, 1'b0};
        vecs[1] = '{64'h1918_1110_0908_0100, 32'h6565_6877, 10, 3, 32'hC69B_E9BB, 1'b0};
        vecs[2] = '{{$urandom, $urandom}, $urandom, 2, -1, 32'd0, 1'b1};
        for (int i = 3; i < NVEC; i++) begin
            vecs[i].key        = {$urandom, $urandom};
            vecs[i].plain      = $urandom;
            vecs[i].hold       = int'($urandom_range(0, 3));
            vecs[i].delay      = int'($urandom_range(0, 5));
            vecs[i].exp_cipher = ref_encrypt(vecs[i].key, vecs[i].plain);
            vecs[i].exp_err    = 1'b0;
        end
        for (int i = 0; i < NVEC; i++) run_block(vecs[i]);

        // Reset in the middle of the rounds, then a fresh block
        core_delay = 0;
        req0_key   = {$urandom, $urandom};
        req0_plain = $urandom;
        req0_valid = 1'b1;
        n = 0;
        while (!req0_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (15) @(negedge clk);
        check("mid_round_key_15", 64'(core_round_key), 64'(ref_round_key(req0_key, 15)));
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
        check("mid_rst_core_start", 64'(core_start), 64'd0);
        check("mid_rst_round_key", 64'(core_round_key), 64'd0);
        check("mid_rst_core_plain", 64'(core_plain), 64'd0);
        check("mid_rst_req0_ready", 64'(req0_ready), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_req0_ready", 64'(req0_ready), 64'd1);
        check("post_rst_resp_valid", 64'(resp_valid), 64'd0);
        v.key        = {$urandom, $urandom};
        v.plain      = $urandom;
        v.hold       = 0;
        v.delay      = 1;
        v.exp_cipher = ref_encrypt(v.key, v.plain);
        v.exp_err    = 1'b0;
        run_block(v);

        // Back-to-back with resp_ready held high
        core_delay = 0;
        resp_ready = 1'b1;
        req0_key   = {$urandom, $urandom};
        req0_plain = $urandom;
        req0_valid = 1'b1;
        starts = 0;
        first  = 0;
        second = 0;
        for (int c = 0; c < 120 && starts < 2; c++) begin
            @(negedge clk);
            if (core_start) begin
                if (starts == 0) first = c;
                else             second = c;
                starts++;
            end
        end
        req0_valid = 1'b0;
        check("b2b_starts", 64'(starts), 64'd2);
        check("b2b_spacing", 64'(second - first), 64'(ROUNDS + 3));
        extra = 0;
        n = 0;
        while (!(req0_ready && !resp_valid) && n < 200) begin
            @(negedge clk);
            if (core_start) extra++;
            n++;
        end
        check("b2b_drain", 64'(req0_ready), 64'd1);
        check("b2b_extra_starts", 64'(extra), 64'd0);
        check("b2b_cipher", 64'(resp_cipher), 64'(ref_encrypt(req0_key, req0_plain)));
        resp_ready = 1'b0;

`ifdef SIMON_TWO_REQ_EN
        core_delay = 0;
        resp_ready = 1'b1;
        req0_key   = {$urandom, $urandom};
        req0_plain = $urandom;
        req1_key   = {$urandom, $urandom};
        req1_plain = $urandom;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        starts = 0;
        for (int c = 0; c < 300 && starts < 4; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                check("rr_resp_id", 64'(resp_id), 64'(starts % 2));
                check("rr_cipher", 64'(resp_cipher), 64'((starts % 2 == 1)
                      ? ref_encrypt(req1_key, req1_plain) : ref_encrypt(req0_key, req0_plain)));
                starts++;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("rr_responses", 64'(starts), 64'd4);
        n = 0;
        while (!(req0_ready || req1_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        resp_ready = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/simon_key_sched_ctrl.md
# simon_key_sched_ctrl

Sequencer and key-schedule engine for the SIMON32/64 `encrypt` core. It does four things: accepts encryption requests (64-bit key plus 32-bit plaintext) over a valid/ready handshake, starts the core, and expands the key on the fly so the core gets one 16-bit round key per cycle. It then collects the core's ciphertext and returns it over a response handshake. It sits between the chip's host/IO interface and the `encrypt` datapath, and can optionally arbitrate two requesters onto the single core.

## Interface
- ROUNDS, 32, number of round keys issued per block (SIMON32/64)
- DONE_TIMEOUT, 64, cycles after `core_start` to wait for `core_done` before flagging an error
- clk  input  1  system clock; all logic on its rising edge
- reset  input  1  synchronous, active-high reset
- req0_valid / req0_ready  input / output  1 / 1  requester 0 handshake
- req0_key  input  64  key words k3..k0, with k0 = [15:0]
- req0_plain  input  32  plaintext
- req1_valid, req1_ready, req1_key, req1_plain  (as req0; present only with SIMON_TWO_REQ_EN)
- resp_valid / resp_ready  output / input  1 / 1  response handshake
- resp_cipher  output  32  ciphertext, latched from `core_cipher`
- resp_id  output  1  index of the requester being served (always 0 without the macro)
- resp_err  output  1  set when the core failed to signal done within DONE_TIMEOUT
- core_start  output  1  one-cycle start pulse to `encrypt`
- core_plain  output  32  plaintext to the core, held from start until done
- core_round_key  output  16  current round key
- core_cipher / core_done  input  32 / 1  core result and completion flag

## Operation
- States: IDLE, RUN, WAIT, RESP.
- **IDLE:** `reqN_ready` = 1 when the state is IDLE and `reset` is low. A transfer completes when valid and ready are both high. It latches key words k0..k3 into a 4×16 shift register and latches the plaintext. Next state is RUN; `core_start` = 1 in the first RUN cycle.
- **RUN:** lasts exactly ROUNDS cycles, with counter r = 0..ROUNDS-1. `core_round_key` = k[r].
  - Register update each cycle: shift out k[r] and shift in k[r+4].
  - k[i+4] = k[i] ^ tmp ^ (tmp ror 1) ^ 16'hFFFC ^ z0[i], where tmp = (k[i+3] ror 3) ^ k[i+1] (all 16-bit).
  - z0, bit index 0 leftmost: 11111010001001010110000111001101111101000100101011000011100110.
  - RUN → WAIT after r = ROUNDS-1.
- **WAIT:** a watchdog counts from `core_start`.
  - `core_done` = 1: latch `core_cipher`, set `resp_err` = 0, go to RESP.
  - Count reaches DONE_TIMEOUT: set `resp_cipher` = 0 and `resp_err` = 1, go to RESP.
  - `core_done` seen during RUN is also accepted; if so, go to RESP right after RUN.
- **RESP:** `resp_valid` = 1 and the response fields stay stable until `resp_ready` is high. Then go to IDLE.
- Reset, at any time including mid-round: go to IDLE; clear the counters and key register. Reset values: `core_start`, `resp_valid`, `resp_err`, `resp_id` = 0; `resp_cipher`, `core_plain`, `core_round_key` = 0. The in-flight request is dropped with no response.

## Timing
- The request handshake at edge T puts the controller in RUN at T+1. `core_start` and k0 are driven during cycle T+1.
- Round key k[r] is valid in cycle T+1+r; k31 is in cycle T+32.
- The earliest `resp_valid` is one cycle after `core_done` is sampled.
- Throughput is one block per at least ROUNDS + 3 cycles. No new request is accepted until the response handshake completes.
- `resp_ready` may be held high; RESP then lasts exactly 1 cycle.

## Configuration
- SIMON_TWO_REQ_EN defined:
  - The req1 ports exist. A round-robin arbiter evaluates in IDLE only.
  - If both valid, grant the requester not served last; the last-served pointer resets to 1, so req0 wins first.
  - Only the granted `reqN_ready` is high. `resp_id` returns the grant.
- Undefined: req1 ports are absent, `resp_id` = 0, and only req0 is served.

## Structure
- Package `simon_pkg`: constants SIMON_Z0 (62-bit), SIMON_C (16'hFFFC), ROUNDS default, and a state enum typedef.
- One sub-module, `simon_key_expand`: the 4-word shift register plus next-key logic, with load/advance inputs and the round index.
- The FSM, watchdog and arbiter stay in the top level.

## Test plan
- Reference vector: key 64'h1918_1110_0908_0100, plain 32'h6565_6877 → keys k0..k3 = 0100, 0908, 1110, 1918; final k31 matches the golden model; `resp_cipher` = 32'hC69B_E9BB, `resp_err` = 0.
- Backpressure: hold `resp_ready` = 0 for 10 cycles → `resp_valid` and `resp_cipher` stable; `req0_ready` = 0 throughout.
- Timeout: the core model never asserts done → `resp_err` = 1 and `resp_cipher` = 0 exactly DONE_TIMEOUT cycles after `core_start`.
- Reset asserted at r = 15, then a new request → no stale response; the new block's k0 is correct.
- With SIMON_TWO_REQ_EN: both requesters continuously valid → grants alternate 0, 1, 0, 1; `resp_id` matches; each ciphertext matches its requester's key.
- Back-to-back requests with `resp_ready` = 1 → spacing of at least ROUNDS + 3 cycles; exactly one `core_start` per block.
